// File: rtl/rf_sequencer_pkg.sv
// Shared encodings for the register-file sequencer: opcodes, ALU ops, FSM states
// and the bit layout of the 32-bit instruction word.
package rf_sequencer_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 3;

    localparam logic [7:0] OP_LOADI = 8'd0;
    localparam logic [7:0] OP_MOV   = 8'd1;
    localparam logic [7:0] OP_ADD   = 8'd2;
    localparam logic [7:0] OP_SUB   = 8'd3;
    localparam logic [7:0] OP_AND   = 8'd4;
    localparam logic [7:0] OP_OR    = 8'd5;

    localparam logic [2:0] ALU_FWD = 3'd0;
    localparam logic [2:0] ALU_ADD = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_SUB = 3'd4;

    localparam int OPC_LSB  = 24;
    localparam int DEST_LSB = 16;
    localparam int SRC1_LSB = 8;
    localparam int SRC2_LSB = 0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_EXEC  = 3'd2,
        ST_WRITE = 3'd3,
        ST_ERR   = 3'd4
    } state_e;

    // Field order matches the bit positions above, so a plain cast unpacks a word.
    typedef struct packed {
        logic [7:0] opcode;
        logic [7:0] dest;
        logic [7:0] src1;
        logic [7:0] src2;
    } instr_t;

endpackage

// File: rtl/rf_seq_decode.sv
// Combinational instruction decode: legality, ALU op selection and whether the
// instruction needs a register-file read.
module rf_seq_decode
    import rf_sequencer_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic [7:0] opcode,
    input  logic [7:0] dest,
    input  logic [7:0] src1,
    input  logic [7:0] src2,
    output logic       legal,
    output logic       needs_read,
    output logic [2:0] alu_op
);

    // A register field is usable only when no bit above the address width is set.
    function automatic logic reg_ok(input logic [7:0] f);
        return (f >> ADDR_W) == 8'd0;
    endfunction

    logic regs_ok;
    assign regs_ok = reg_ok(dest) && reg_ok(src1) && reg_ok(src2);

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
        legal      = 1'b0;
        needs_read = 1'b0;
        alu_op     = ALU_FWD;
        case (opcode)
            OP_LOADI: legal = reg_ok(dest);
            OP_MOV: begin
                legal      = regs_ok;
                needs_read = 1'b1;
                alu_op     = ALU_FWD;
            end
            OP_ADD: begin
                legal      = regs_ok;
                needs_read = 1'b1;
                alu_op     = ALU_ADD;
            end
            OP_SUB: begin
                legal      = regs_ok;
                needs_read = 1'b1;
                alu_op     = ALU_SUB;
            end
            OP_AND: begin
                legal      = regs_ok;
                needs_read = 1'b1;
                alu_op     = ALU_AND;
            end
            OP_OR: begin
                legal      = regs_ok;
                needs_read = 1'b1;
                alu_op     = ALU_OR;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/rf_sequencer.sv
// Multi-cycle sequencer driving an 8x8 register file and a combinational ALU,
// one instruction at a time: IDLE -> READ -> EXEC -> WRITE (loadi skips to WRITE).
module rf_sequencer
    import rf_sequencer_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              instr_valid,
    input  logic [31:0]       instr,
    output logic              instr_ready,
    output logic [ADDR_W-1:0] rf_out1addr,
    output logic [ADDR_W-1:0] rf_out2addr,
    input  logic [DATA_W-1:0] rf_out1,
    input  logic [DATA_W-1:0] rf_out2,
    output logic [ADDR_W-1:0] rf_inaddr,
    output logic [DATA_W-1:0] rf_in,
    output logic              rf_we,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_op,
    input  logic [DATA_W-1:0] alu_result,
    output logic              done,
    output logic              illegal,
    output logic [CNT_W-1:0]  retired
);

    instr_t fields;
    assign fields = instr_t'(instr);

    logic       dec_legal;
    logic       dec_needs_read;
    logic [2:0] dec_alu_op;

    rf_seq_decode #(.ADDR_W(ADDR_W)) u_decode (
        .opcode     (fields.opcode),
        .dest       (fields.dest),
        .src1       (fields.src1),
        .src2       (fields.src2),
        .legal      (dec_legal),
        .needs_read (dec_needs_read),
        .alu_op     (dec_alu_op)
    );

    state_e            state_q,       state_d;
    logic [ADDR_W-1:0] rf_out1addr_q, rf_out1addr_d;
    logic [ADDR_W-1:0] rf_out2addr_q, rf_out2addr_d;
    logic [ADDR_W-1:0] rf_inaddr_q,   rf_inaddr_d;
    logic [DATA_W-1:0] result_q,      result_d;
    logic              rf_we_q,       rf_we_d;
    logic              done_q,        done_d;
    logic              illegal_q,     illegal_d;
    logic [2:0]        alu_op_q,      alu_op_d;
    logic [CNT_W-1:0]  retired_q,     retired_d;

    always_comb begin
        state_d       = state_q;
        rf_out1addr_d = rf_out1addr_q;
        rf_out2addr_d = rf_out2addr_q;
        rf_inaddr_d   = rf_inaddr_q;
        result_d      = result_q;
        alu_op_d      = alu_op_q;
        retired_d     = retired_q;
        rf_we_d       = 1'b0;
        done_d        = 1'b0;
        illegal_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (instr_valid) begin
                    if (!dec_legal) begin
                        state_d   = ST_ERR;
                        illegal_d = 1'b1;
                    end else begin
                        rf_inaddr_d = fields.dest[ADDR_W-1:0];
                        alu_op_d    = dec_alu_op;
                        if (dec_needs_read) begin
                            state_d       = ST_READ;
                            rf_out1addr_d = fields.src1[ADDR_W-1:0];
                            rf_out2addr_d = fields.src2[ADDR_W-1:0];
                        end else begin
                            state_d   = ST_WRITE;
                            result_d  = DATA_W'(fields.src2);
                            rf_we_d   = 1'b1;
                            done_d    = 1'b1;
                            retired_d = retired_q + CNT_W'(1);
                        end
                    end
                end
            end
            ST_READ: state_d = ST_EXEC;
            ST_EXEC: begin
                state_d   = ST_WRITE;
                result_d  = alu_result;
                rf_we_d   = 1'b1;
                done_d    = 1'b1;
                retired_d = retired_q + CNT_W'(1);
            end
            ST_WRITE: state_d = ST_IDLE;
            ST_ERR:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            rf_out1addr_q <= '0;
            rf_out2addr_q <= '0;
            rf_inaddr_q   <= '0;
            result_q      <= '0;
            rf_we_q       <= 1'b0;
            done_q        <= 1'b0;
            illegal_q     <= 1'b0;
            alu_op_q      <= ALU_FWD;
            retired_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q       <= state_d;
            rf_out1addr_q <= rf_out1addr_d;
            rf_out2addr_q <= rf_out2addr_d;
            rf_inaddr_q   <= rf_inaddr_d;
            result_q      <= result_d;
            rf_we_q       <= rf_we_d;
            done_q        <= done_d;
            illegal_q     <= illegal_d;
            alu_op_q      <= alu_op_d;
            retired_q     <= retired_d;
        end
    end

    assign instr_ready = (state_q == ST_IDLE);
    assign rf_out1addr = rf_out1addr_q;
    assign rf_out2addr = rf_out2addr_q;
    assign rf_inaddr   = rf_inaddr_q;
    assign rf_in       = result_q;
    assign rf_we       = rf_we_q;
    assign done        = done_q;
    assign illegal     = illegal_q;
    assign alu_op      = alu_op_q;
    assign retired     = retired_q;

    // Read data only arrives at the start of EXEC, so operands are gated straight through.
    assign alu_a = (state_q == ST_EXEC) ? rf_out1 : '0;
    assign alu_b = (state_q == ST_EXEC) ? rf_out2 : '0;

endmodule

// File: tb/tb_rf_sequencer.sv
// Self-checking bench: register file and ALU environment, an instruction-level
// reference model compared every cycle, directed cases and randomized traffic.
module tb_rf_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic [2:0]  rf_out1addr, rf_out2addr, rf_inaddr;
    logic [7:0]  rf_out1 = 8'h00;
    logic [7:0]  rf_out2 = 8'h00;
    logic [7:0]  rf_in;
    logic        rf_we;
    logic [7:0]  alu_a, alu_b, alu_result;
    logic [2:0]  alu_op;
    logic        done, illegal;
    logic [15:0] retired;

    int n_checks = 0;
    int n_fail   = 0;
    int tb_cyc   = 0;
    int last_acc = 0;
    int preset_cnt = 0;

    logic [7:0]  tb_regs [8] = '{default: 8'h00};
    logic [7:0]  m_regs  [8] = '{default: 8'h00};
    logic [15:0] m_ret = 16'h0000;

    rf_sequencer dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .rf_out1addr (rf_out1addr),
        .rf_out2addr (rf_out2addr),
        .rf_out1     (rf_out1),
        .rf_out2     (rf_out2),
        .rf_inaddr   (rf_inaddr),
        .rf_in       (rf_in),
        .rf_we       (rf_we),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_result  (alu_result),
        .done        (done),
        .illegal     (illegal),
        .retired     (retired)
    );

    always #5 clk = ~clk;
    always @(posedge clk) tb_cyc <= tb_cyc + 1;

    // Environment: regfile reads on posedge, writes on negedge; combinational ALU.
    always @(posedge clk) begin
        rf_out1 <= tb_regs[rf_out1addr];
        rf_out2 <= tb_regs[rf_out2addr];
    end
    always @(negedge clk) if (rf_we) tb_regs[rf_inaddr] <= rf_in;

    always_comb begin
        case (alu_op)
            3'd0:    alu_result = alu_b;
            3'd1:    alu_result = alu_a + alu_b;
            3'd2:    alu_result = alu_a & alu_b;
            3'd3:    alu_result = alu_a | alu_b;
            3'd4:    alu_result = alu_a - alu_b;
            default: alu_result = 8'h00;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(input int op, input int d, input int s1, input int s2);
        return {8'(op), 8'(d), 8'(s1), 8'(s2)};
    endfunction

    // Reference model: instruction-level timeline in cycles after the accept edge.
    initial begin : model
        int n, ready_cyc, read_cyc, exec_cyc, wb_cyc, err_cyc, preset_seen;
        logic [7:0] op, d, s1, s2, e_a, e_b, e_wd;
        logic [2:0] e_op, e_wa, e_r1, e_r2;
        n = 0; ready_cyc = 0; read_cyc = -1; exec_cyc = -1; wb_cyc = -1; err_cyc = -1;
        preset_seen = 0;
        e_a = 0; e_b = 0; e_wd = 0; e_op = 0; e_wa = 0; e_r1 = 0; e_r2 = 0;
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                n = 0; ready_cyc = 0; read_cyc = -1; exec_cyc = -1; wb_cyc = -1; err_cyc = -1;
                m_ret = 16'h0000;
                #1;
                check("rst_rf_we", 32'(rf_we), 0);
                check("rst_done", 32'(done), 0);
                check("rst_illegal", 32'(illegal), 0);
                check("rst_retired", 32'(retired), 0);
            end else begin
                n++;
                if (preset_cnt != preset_seen) begin
                    preset_seen = preset_cnt;
                    m_ret = 16'hFFFF;
                end
                if (n > ready_cyc && instr_valid) begin
                    op = instr[31:24]; d = instr[23:16]; s1 = instr[15:8]; s2 = instr[7:0];
                    if (!(op <= 8'd5 && d < 8'd8 && (op == 8'd0 || (s1 < 8'd8 && s2 < 8'd8)))) begin
                        err_cyc   = n;
                        ready_cyc = n + 1;
                    end else if (op == 8'd0) begin
                        wb_cyc = n; e_wa = d[2:0]; e_wd = s2;
                        ready_cyc = n + 1;
                    end else begin
                        e_r1 = s1[2:0]; e_r2 = s2[2:0]; e_wa = d[2:0];
                        e_a = m_regs[e_r1]; e_b = m_regs[e_r2];
                        case (op)
                            8'd1:    begin e_wd = e_b;       e_op = 3'd0; end
                            8'd2:    begin e_wd = e_a + e_b; e_op = 3'd1; end
                            8'd3:    begin e_wd = e_a - e_b; e_op = 3'd4; end
                            8'd4:    begin e_wd = e_a & e_b; e_op = 3'd2; end
                            default: begin e_wd = e_a | e_b; e_op = 3'd3; end
                        endcase
                        read_cyc = n; exec_cyc = n + 1; wb_cyc = n + 2; ready_cyc = n + 3;
                    end
                end
                #1;
                check("ready", 32'(instr_ready), 32'(n >= ready_cyc));
                check("rf_we", 32'(rf_we), 32'(n == wb_cyc));
                check("done", 32'(done), 32'(n == wb_cyc));
                check("illegal", 32'(illegal), 32'(n == err_cyc));
                if (n == wb_cyc) begin
                    m_ret++;
                    m_regs[e_wa] = e_wd;
                    check("rf_inaddr", 32'(rf_inaddr), 32'(e_wa));
                    check("rf_in", 32'(rf_in), 32'(e_wd));
                end
                if (n == read_cyc) begin
                    check("rf_out1addr", 32'(rf_out1addr), 32'(e_r1));
                    check("rf_out2addr", 32'(rf_out2addr), 32'(e_r2));
                end
                if (n == exec_cyc) begin
                    check("alu_a", 32'(alu_a), 32'(e_a));
                    check("alu_b", 32'(alu_b), 32'(e_b));
                    check("alu_op", 32'(alu_op), 32'(e_op));
                end
                check("retired", 32'(retired), 32'(m_ret));
            end
        end
    end

    // Present an instruction and keep instr_valid high until it is accepted.
    task automatic send(input logic [31:0] w);
        int waited = 0;
        @(negedge clk);
        instr = w;
        instr_valid = 1'b1;
        while (!instr_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!instr_ready) check("accept_timeout", 32'(instr_ready), 1);
        @(posedge clk);
        #1 last_acc = tb_cyc;
    endtask

    task automatic idle(input int cycles);
        @(negedge clk);
        instr_valid = 1'b0;
        repeat (cycles) @(negedge clk);
    endtask

    function automatic logic [7:0] rnd_reg();
        return ($urandom_range(0, 7) == 0) ? 8'($urandom_range(8, 255)) : 8'($urandom_range(0, 7));
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int a0, a1, a2;
        logic [7:0] op, s2;
        reset_n = 1'b0;
        instr_valid = 1'b0;
        instr = '0;
        @(negedge clk);
        check("init_ready", 32'(instr_ready), 1);
        check("init_alu_op", 32'(alu_op), 0);
        check("init_rf_in", 32'(rf_in), 0);
        check("init_inaddr", 32'(rf_inaddr), 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // loadi r5,12 then dependent add r3,r5,r5.
        send(mk(0, 5, 0, 12));
        send(mk(2, 3, 5, 5));
        idle(5);
        check("r5_loadi", 32'(tb_regs[5]), 32'h0C);
        check("r3_add", 32'(tb_regs[3]), 32'h18);
        check("retired_two", 32'(retired), 2);

        // Wrapping sub, then and/or of F0 and 3C.
        send(mk(0, 3, 0, 10));
        send(mk(3, 2, 3, 5));
        send(mk(0, 1, 0, 8'hF0));
        send(mk(0, 4, 0, 8'h3C));
        send(mk(4, 6, 1, 4));
        send(mk(5, 7, 1, 4));
        idle(5);
        check("r2_sub_wrap", 32'(tb_regs[2]), 32'hFE);
        check("r6_and", 32'(tb_regs[6]), 32'h30);
        check("r7_or", 32'(tb_regs[7]), 32'hFC);
        check("model_r7", 32'(m_regs[7]), 32'hFC);

        // Bad opcode, then a loadi whose dest field is out of range.
        send(mk(9, 1, 1, 1));
        send(mk(0, 8'h08, 0, 8'h77));
        idle(4);
        check("retired_after_illegal", 32'(retired), 8);
        check("r0_untouched", 32'(tb_regs[0]), 32'h00);

        // Valid held high across three dependent adds.
        send(mk(0, 0, 0, 1));
        send(mk(2, 1, 0, 0));
        a0 = last_acc;
        send(mk(2, 2, 1, 1));
        a1 = last_acc;
        send(mk(2, 3, 2, 2));
        a2 = last_acc;
        idle(5);
        check("accept_spacing_1", 32'(a1 - a0), 4);
        check("accept_spacing_2", 32'(a2 - a1), 4);
        check("r3_chain", 32'(tb_regs[3]), 32'h08);

        // Reset during EXEC of add r6,r1,r1: no write may reach r6.
        send(mk(2, 6, 1, 1));
        @(negedge clk);
        instr_valid = 1'b0;
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_rf_we", 32'(rf_we), 0);
        check("midrst_retired", 32'(retired), 0);
        check("midrst_ready", 32'(instr_ready), 1);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("midrst_r6_kept", 32'(tb_regs[6]), 32'h30);

        // Counter wrap from FFFF.
        @(negedge clk);
        force dut.retired_q = 16'hFFFF;
        preset_cnt++;
        #1 release dut.retired_q;
        send(mk(0, 2, 0, 8'h5A));
        idle(3);
        check("retired_wrap", 32'(retired), 0);
        check("r2_after_wrap", 32'(tb_regs[2]), 32'h5A);

        // Randomized traffic with occasional gaps in instr_valid.
        for (int i = 0; i < 120; i++) begin
            op = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(6, 255)) : 8'($urandom_range(0, 5));
            s2 = (op == 8'd0) ? 8'($urandom) : rnd_reg();
            send({op, rnd_reg(), rnd_reg(), s2});
            if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 3));
        end
        idle(6);
        for (int r = 0; r < 8; r++) check("final_reg", 32'(tb_regs[r]), 32'(m_regs[r]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rf_sequencer.md
Name: rf_sequencer

Overview:
- Multi-cycle control unit that sequences the 8x8 register file and the ALU for one instruction at a time.
- Accepts a 32-bit instruction over a valid/ready handshake and drives the register file read/write addresses and the write enable.
- Drives ALU operands and op code, then writes the result back.
- Sits between instruction fetch and the regfile/ALU datapath. The regfile revision paired with this block adds a write-enable input; the write still occurs on the negedge.

Parameters:
- DATA_W, 8: register/data width.
- ADDR_W, 3: register address width (8 registers).
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; regfile reads on posedge, writes on negedge.
- reset_n  in  1  asynchronous, active-low reset.
- instr_valid  in  1  instruction present.
- instr  in  32  [31:24] opcode, [23:16] dest, [15:8] src1, [7:0] src2/imm.
- instr_ready  out  1  sequencer can accept an instruction.
- rf_out1addr  out  ADDR_W  regfile read port 1 address.
- rf_out2addr  out  ADDR_W  regfile read port 2 address.
- rf_out1  in  DATA_W  regfile read data 1.
- rf_out2  in  DATA_W  regfile read data 2.
- rf_inaddr  out  ADDR_W  regfile write address.
- rf_in  out  DATA_W  regfile write data.
- rf_we  out  1  regfile write enable.
- alu_a  out  DATA_W  ALU operand A.
- alu_b  out  DATA_W  ALU operand B.
- alu_op  out  3  0 FWD(B), 1 ADD, 2 AND, 3 OR, 4 SUB.
- alu_result  in  DATA_W  combinational ALU result.
- done  out  1  one-cycle pulse on the writeback cycle.
- illegal  out  1  one-cycle pulse on a rejected instruction.
- retired  out  CNT_W  count of completed writebacks.

Behaviour:
- Opcodes:
  - 0 loadi: dest = imm[7:0].
  - 1 mov: dest = reg[src2].
  - 2 add: dest = src1 + src2.
  - 3 sub: dest = src1 - src2.
  - 4 and: dest = src1 & src2.
  - 5 or: dest = src1 | src2.
- Arithmetic is mod 2^DATA_W, performed in the ALU; the sequencer does no arithmetic.
- States: IDLE, READ, EXEC, WRITE, ERR.
- Reset (async, asserted): state=IDLE, all address/data/operand registers 0, rf_we=0, done=0, illegal=0, retired=0, alu_op=0. Any in-flight instruction is discarded without a write. instr_ready=1 once reset_n deasserts.
- IDLE:
  - instr_ready=1.
  - Accept on the posedge with instr_valid=1; capture opcode, dest, src1, src2/imm.
  - Next state: READ for opcodes 1-5, WRITE for loadi.
  - Next state: ERR for opcode >5, or for any register field with bits [7:ADDR_W] nonzero (for loadi, dest only is checked).
- READ (1 cycle): rf_out1addr=src1, rf_out2addr=src2; the regfile captures at the closing posedge. Next state EXEC.
- EXEC (1 cycle):
  - alu_a=rf_out1, alu_b=rf_out2, alu_op decoded.
  - alu_result registered into the result register at the closing posedge.
  - Next state WRITE.
- WRITE (1 cycle):
  - rf_we=1, rf_inaddr=dest, rf_in=result (imm for loadi); held stable for the whole cycle, so the negedge write is clean.
  - done=1; retired increments and wraps from 2^CNT_W-1 to 0.
  - Next state IDLE.
- ERR (1 cycle): illegal=1, rf_we=0, no counter change. Next state IDLE.
- instr_ready=0 in every state except IDLE. instr_valid is ignored while not ready; no buffering.
- Latency from the accept edge: ALU ops take 3 cycles to the writeback cycle, then IDLE; loadi takes 1 cycle. Maximum throughput is 1 ALU instruction per 4 cycles.
- Back-to-back dependency: the write completes at the WRITE negedge, before the next READ posedge, so no forwarding or stall is needed.
- Outputs are registered. rf_we and done are high only in WRITE; illegal is high only in ERR.
- Outside READ and EXEC, the read addresses hold their last values.
- dest == src1 == src2 is legal.

Decomposition:
- Shared package:
  - opcode constants OP_LOADI..OP_OR.
  - ALU op constants ALU_FWD..ALU_SUB.
  - state encoding.
  - instruction field bit positions.
  - DATA_W/ADDR_W defaults.
- Natural sub-module: rf_seq_decode, combinational; maps opcode and fields to legal flag, alu_op and needs_read.

Test Plan:
- Reset mid-instruction: assert reset_n=0 during EXEC of add -> rf_we=0 immediately, state IDLE, retired=0, no write to dest.
- loadi r5,12 then add r3,r5,r5 -> WRITE with rf_inaddr=5, rf_in=12 one cycle after accept; next instruction has alu_a=alu_b=12, rf_in=24 into r3; done pulses twice, retired=2.
- sub r2,r3,r5 with r3=10, r5=12 -> rf_in=8'hFE (wrap); and/or with 8'hF0, 8'h3C -> 8'h30 / 8'hFC.
- Opcode 9, then dest field 8'h08 -> illegal pulses once each, rf_we never 1, retired unchanged, instr_ready back high after 2 cycles.
- instr_valid held high continuously with 3 queued adds -> each accepted exactly once, at 4-cycle spacing, instr_ready low 3 cycles per add; the dependent add reads the freshly written value.
- retired preset near wrap (force to 16'hFFFF) then one loadi -> retired=0.
